skew_input_buffer: RTL and testbench

Parametrised input staging buffer for the systolic array. It stores up to DEPTH input vectors, each ROWS elements of BITWIDTH bits, in a FIFO. On each pop it emits the vector diagonally skewed: row r is delayed r cycles so the array edge sees a wavefront. It generalises the fixed 3-row read-only buffer with configurable width, row count and depth, a write port, full/empty status, and a selectable skew/bypass mode.

---
 rtl/sysbuf_pkg.sv | 20 ++
 rtl/skew_delay_line.sv | 49 ++++
 rtl/skew_input_buffer.sv | 122 ++++++++++++
 tb/tb_skew_input_buffer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysbuf_pkg.sv
// Shared types for the systolic input staging buffer: count-width helper,
// default vector shape and the output mode encoding.
package sysbuf_pkg;

  localparam int DEF_BITWIDTH = 8;
  localparam int DEF_ROWS     = 3;

  // Default-shaped vector; the top redeclares it with its own parameters.
  typedef logic [DEF_ROWS-1:0][DEF_BITWIDTH-1:0] vec_t;

  typedef enum logic {
    MODE_BYPASS = 1'b0,
    MODE_SKEW   = 1'b1
  } mode_e;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Per-row delay line: DELAY register stages carrying an element and its valid.
// DELAY=0 degenerates to a wire.
module skew_delay_line #(
  parameter int BITWIDTH = 8,
  parameter int DELAY    = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_vld,
  input  logic [BITWIDTH-1:0] in_dat,
  output logic                out_vld,
  output logic [BITWIDTH-1:0] out_dat
);

  if (DELAY == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk, rst};
    assign out_vld = in_vld;
    assign out_dat = in_dat;
  end else begin : g_shift
    logic [DELAY-1:0]               vld_q, vld_d;
    logic [DELAY-1:0][BITWIDTH-1:0] dat_q, dat_d;

    always_comb begin
      vld_d    = '0;
      dat_d    = '0;
      vld_d[0] = in_vld;
      dat_d[0] = in_dat;
      for (int i = 1; i < DELAY; i++) begin
        vld_d[i] = vld_q[i-1];
        dat_d[i] = dat_q[i-1];
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        vld_q <= '0;
        dat_q <= '0;
      end else begin
        vld_q <= vld_d;
        dat_q <= dat_d;
      end
    end

    assign out_vld = vld_q[DELAY-1];
    assign out_dat = dat_q[DELAY-1];
  end

endmodule

// File: rtl/skew_input_buffer.sv
// Input staging FIFO for the systolic array; popped vectors leave as a
// diagonal wavefront (row r delayed r cycles) or all rows aligned in bypass.
module skew_input_buffer
  import sysbuf_pkg::*;
#(
  parameter int BITWIDTH = 8,
  parameter int ROWS     = 3,
  parameter int DEPTH    = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wr_en,
  input  logic [ROWS-1:0][BITWIDTH-1:0]     wr_data,
  input  logic                              read,
  input  logic                              skew_en,
  output logic [ROWS-1:0]                   o_valid,
  output logic [ROWS-1:0][BITWIDTH-1:0]     o_data,
  output logic                              o_full,
  output logic                              o_empty,
  output logic [$clog2(DEPTH+1)-1:0]        o_count,
  output logic                              o_busy,
  output logic                              o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  typedef logic [ROWS-1:0][BITWIDTH-1:0] row_vec_t;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  // vld_pipe[k] = a vector popped k edges ago; the extra top bit holds
  // busy high one cycle past the last row's valid.
  logic [ROWS:0] vld_pipe_q, vld_pipe_d;
  row_vec_t      dat0_q, dat0_d;
  mode_e         mode_q, mode_d;
  logic          ovf_q, ovf_d;
  row_vec_t      mem [DEPTH];

  logic push, pop, full, empty;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = wr_en && !full;
  assign pop   = read && !empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    mode_d     = mode_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: ;
    endcase
    vld_pipe_d = {vld_pipe_q[ROWS-1:0], pop};
    dat0_d     = pop ? mem[rd_ptr_q] : '0;
    ovf_d      = wr_en && full;
    // Mode only switches with an empty pipeline so no vector is torn.
    if (!o_busy && !pop) mode_d = mode_e'(skew_en);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      vld_pipe_q <= '0;
      dat0_q     <= '0;
      mode_q     <= MODE_SKEW;
      ovf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      vld_pipe_q <= vld_pipe_d;
      dat0_q     <= dat0_d;
      mode_q     <= mode_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end

  logic [ROWS-1:0] line_vld;
  row_vec_t        line_dat;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    skew_delay_line #(
      .BITWIDTH (BITWIDTH),
      .DELAY    (r)
    ) u_line (
      .clk     (clk),
      .rst     (rst),
      .in_vld  (vld_pipe_q[0]),
      .in_dat  (dat0_q[r]),
      .out_vld (line_vld[r]),
      .out_dat (line_dat[r])
    );
  end

  always_comb begin
    o_valid = '0;
    o_data  = '0;
    for (int r = 0; r < ROWS; r++) begin
      o_valid[r] = (mode_q == MODE_SKEW) ? line_vld[r] : vld_pipe_q[0];
      if (o_valid[r]) o_data[r] = (mode_q == MODE_SKEW) ? line_dat[r] : dat0_q[r];
    end
  end

  assign o_full     = full;
  assign o_empty    = empty;
  assign o_count    = count_q;
  assign o_busy     = |vld_pipe_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_skew_input_buffer.sv
// Bench for skew_input_buffer: directed scenarios plus random traffic, all
// checked every cycle against a queue + pop-history reference model.
module tb_skew_input_buffer;

  localparam int BW    = 8;
  localparam int ROWS  = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int MAXE  = 2048;

  typedef logic [ROWS-1:0][BW-1:0] vec_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            wr_en, read, skew_en;
  vec_t            wr_data;
  logic [ROWS-1:0] o_valid;
  vec_t            o_data;
  logic            o_full, o_empty, o_busy, o_overflow;
  logic [CW-1:0]   o_count;

  skew_input_buffer #(.BITWIDTH(BW), .ROWS(ROWS), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .read       (read),
    .skew_en    (skew_en),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .o_count    (o_count),
    .o_busy     (o_busy),
    .o_overflow (o_overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h want %0h", tag, $time, act, exp);
    end
  endtask

  // Reference model: stored vectors in a queue, every pop remembered by the
  // edge number it happened on; outputs are looked up from that history.
  vec_t q[$];
  bit   pf[MAXE];
  vec_t pd[MAXE];
  int   e    = 0;
  int   base = 1;
  bit   m_skew = 1'b1;
  bit   m_ovf  = 1'b0;

  function automatic bit popped(input int k);
    if (k < base || k < 0 || k >= MAXE) return 1'b0;
    return pf[k];
  endfunction

  function automatic bit m_busy();
    for (int k = e - ROWS; k <= e; k++)
      if (popped(k)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    q.delete();
    m_skew = 1'b1;
    m_ovf  = 1'b0;
    base   = e + 1;
  endtask

  task automatic edge_update();
    bit busy_pre, full, empty, pop, push;
    busy_pre = m_busy();
    full     = (q.size() == DEPTH);
    empty    = (q.size() == 0);
    e++;
    if (!rst) begin
      model_reset();
      return;
    end
    pop  = read && !empty;
    push = wr_en && !full;
    if (!busy_pre && !pop) m_skew = skew_en;
    pf[e] = pop;
    if (pop)  pd[e] = q.pop_front();
    if (push) q.push_back(wr_data);
    m_ovf = wr_en && full;
  endtask

  task automatic check_all();
    logic [ROWS-1:0] ev;
    vec_t            ed;
    int              k;
    ev = '0;
    ed = '0;
    for (int r = 0; r < ROWS; r++) begin
      k     = m_skew ? e - r : e;
      ev[r] = popped(k);
      if (ev[r]) ed[r] = pd[k][r];
    end
    chk("o_valid", o_valid, ev);
    chk("o_data", o_data, ed);
    chk("o_count", o_count, q.size());
    chk("o_full", o_full, q.size() == DEPTH);
    chk("o_empty", o_empty, q.size() == 0);
    chk("o_busy", o_busy, m_busy());
    chk("o_overflow", o_overflow, m_ovf);
  endtask

  task automatic step();
    @(posedge clk);
    edge_update();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    wr_en = 1'b0;
    read  = 1'b0;
    repeat (n) step();
  endtask

  task automatic push_vec(input vec_t v);
    wr_en   = 1'b1;
    read    = 1'b0;
    wr_data = v;
    step();
    wr_en   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int since, row_last_first, busy_fall;
    vec_t v;

    rst = 1'b0; wr_en = 1'b0; read = 1'b0; skew_en = 1'b1; wr_data = '0;
    model_reset();
    #2;
    check_all();
    chk("rst_empty", o_empty, 1'b1);
    chk("rst_valid", o_valid, '0);
    repeat (2) step();
    rst = 1'b1;
    idle(1);

    // Two pushes then a 2-cycle read: wavefront across the rows.
    v = '0; v[0] = 8'h11; v[1] = 8'h22; v[2] = 8'h33; v[3] = 8'h77; push_vec(v);
    v = '0; v[0] = 8'h44; v[1] = 8'h55; v[2] = 8'h66; v[3] = 8'h88; push_vec(v);
    read = 1'b1;
    step();
    chk("wave_r0_first", o_data[0], 8'h11);
    step();
    chk("wave_r0_second", o_data[0], 8'h44);
    chk("wave_r1_first", o_data[1], 8'h22);
    idle(ROWS + 2);

    // Fill, overflow, then drain across the pointer wrap.
    for (int i = 0; i < DEPTH; i++) push_vec(vec_t'($urandom));
    chk("fill_full", o_full, 1'b1);
    chk("fill_count", o_count, DEPTH);
    push_vec(vec_t'($urandom));
    chk("ovf_pulse", o_overflow, 1'b1);
    chk("ovf_count", o_count, DEPTH);
    idle(1);
    chk("ovf_clear", o_overflow, 1'b0);
    read = 1'b1;
    repeat (DEPTH) step();
    idle(ROWS + 2);

    // Simultaneous push/pop at count 2, then at count 0.
    push_vec(vec_t'($urandom));
    push_vec(vec_t'($urandom));
    wr_en = 1'b1; read = 1'b1; wr_data = vec_t'($urandom);
    step();
    chk("pp_count2", o_count, 2);
    wr_en = 1'b0;
    repeat (2) step();
    idle(ROWS + 2);
    wr_en = 1'b1; read = 1'b1; wr_data = vec_t'($urandom);
    step();
    chk("pp_count0", o_count, 1);
    chk("pp_nofall", o_valid, '0);
    wr_en = 1'b0; read = 1'b1;
    step();
    idle(ROWS + 2);

    // Bypass while idle; request skew mid-stream (deferred until drained).
    skew_en = 1'b0;
    idle(1);
    for (int i = 0; i < 3; i++) push_vec(vec_t'($urandom));
    read = 1'b1;
    step();
    chk("byp_all_rows", o_valid, {ROWS{1'b1}});
    step();
    skew_en = 1'b1;
    step();
    chk("byp_deferred", o_valid, {ROWS{1'b1}});
    idle(ROWS + 4);

    // Asynchronous reset with vectors in flight.
    push_vec(vec_t'($urandom));
    push_vec(vec_t'($urandom));
    push_vec(vec_t'($urandom));
    read = 1'b1;
    repeat (2) step();
    read = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("arst_valid", o_valid, '0);
    chk("arst_empty", o_empty, 1'b1);
    chk("arst_count", o_count, 0);
    step();
    rst = 1'b1;
    idle(ROWS + 3);

    // Continuous read: last-row offset and busy fall time.
    skew_en = 1'b1;
    idle(1);
    for (int i = 0; i < DEPTH; i++) push_vec(vec_t'($urandom));
    read = 1'b1;
    step();
    since = 0;
    row_last_first = -1;
    busy_fall = -1;
    if (o_valid[ROWS-1]) row_last_first = 0;
    while (busy_fall < 0 && since < 40) begin
      if (since == DEPTH - 1) read = 1'b0;
      step();
      since++;
      if (row_last_first < 0 && o_valid[ROWS-1]) row_last_first = since;
      if (!o_busy) busy_fall = since;
    end
    read = 1'b0;
    chk("last_row_offset", row_last_first, ROWS - 1);
    chk("busy_fall", busy_fall, DEPTH + ROWS);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      wr_en   = ($urandom % 3) != 0;
      read    = ($urandom % 2) != 0;
      wr_data = vec_t'($urandom);
      if (($urandom % 16) == 0) skew_en = ~skew_en;
      step();
    end
    idle(ROWS + 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
